seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder_pkg.sv | 56 +++++
 rtl/seg_scan_decoder_seg_pattern_decode.sv | 41 ++++
 rtl/seg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan decoder:
// segment pattern constants (active-low {g,f,e,d,c,b,a}), the scan
// state enumeration, the default stability threshold and anode helpers.
// Optional feature macro: SEG_HEX_DECODE_EN (hex digits A..F accepted).
package seg_scan_decoder_pkg;

   localparam int STABLE_CYCLES_DEF = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_e;

   // True when exactly one active-low anode is driven.
   function automatic logic anode_onehot(input logic [3:0] an);
      logic res;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

   // Digit position of a one-hot active-low anode (0 = least significant).
   function automatic logic [1:0] anode_index(input logic [3:0] an);
      logic [1:0] res;
      case (an)
         4'b1110: res = 2'd0;
         4'b1101: res = 2'd1;
         4'b1011: res = 2'd2;
         4'b0111: res = 2'd3;
         default: res = 2'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_seg_pattern_decode.sv
// Combinational segment pattern to BCD/hex nibble decoder.
// Optional feature macro: SEG_HEX_DECODE_EN (adds A..F as valid patterns).
module seg_pattern_decode
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       valid
);

   // Map each legal active-low pattern to its nibble; everything else is invalid.
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      case (seg)
         SEG_0: nibble = 4'h0;
         SEG_1: nibble = 4'h1;
         SEG_2: nibble = 4'h2;
         SEG_3: nibble = 4'h3;
         SEG_4: nibble = 4'h4;
         SEG_5: nibble = 4'h5;
         SEG_6: nibble = 4'h6;
         SEG_7: nibble = 4'h7;
         SEG_8: nibble = 4'h8;
         SEG_9: nibble = 4'h9;
`ifdef SEG_HEX_DECODE_EN
         SEG_A: nibble = 4'hA;
         SEG_B: nibble = 4'hB;
         SEG_C: nibble = 4'hC;
         SEG_D: nibble = 4'hD;
         SEG_E: nibble = 4'hE;
         SEG_F: nibble = 4'hF;
`endif
         default: begin
            nibble = 4'h0;
            valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the 4-digit number shown on a multiplexed 7-segment display by
// watching its anode/segment lines. A digit is captured once its pattern is
// stable for STABLE_CYCLES registered samples; a full frame is published
// once all four positions have been captured.
// Optional feature macro: SEG_HEX_DECODE_EN (hex digits A..F accepted).
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic        dp,
   input  logic [3:0]  an,
   output logic [15:0] value,
   output logic [3:0]  dp_seen,
   output logic        frame_valid,
   output logic        decode_err
);

   localparam logic [7:0] CNT_LIMIT = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYCLES - 1);

   logic [3:0]  an_r;
   logic [6:0]  seg_r;
   logic        dp_r;
   logic [11:0] pat_r;
   logic [7:0]  cnt_r;
   scan_state_e state_r;
   logic [3:0]  captured_r;
   logic [15:0] shadow_val_r;
   logic [3:0]  shadow_dp_r;
   logic [15:0] value_r;
   logic [3:0]  dp_seen_r;
   logic        frame_valid_r;
   logic        decode_err_r;

   logic [11:0] sample_s;
   logic        onehot_s;
   logic        same_s;
   logic [1:0]  idx_s;
   logic [3:0]  dec_nib_s;
   logic        dec_vld_s;
   logic        frame_done_s;
   logic [3:0]  cap_mask_s;
   scan_state_e state_nx_s;
   logic [7:0]  cnt_nx_s;
   logic [11:0] pat_nx_s;
   logic        cap_s;
   logic        err_s;

   assign sample_s     = {an_r, seg_r, dp_r};
   assign onehot_s     = anode_onehot(an_r);
   assign same_s       = (sample_s == pat_r);
   assign idx_s        = anode_index(an_r);
   assign frame_done_s = (captured_r == 4'hF);
   assign cap_mask_s   = cap_s ? ~an_r : 4'h0;

   seg_pattern_decode u_decode (
      .seg    (seg_r),
      .nibble (dec_nib_s),
      .valid  (dec_vld_s)
   );

   // Register the raw display lines once; all decisions use these copies.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_r  <= 4'hF;
         seg_r <= 7'h7F;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an;
         seg_r <= seg;
         dp_r  <= dp;
      end
   end

   // Next-state logic: stability counting, capture and reject decisions.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      pat_nx_s   = pat_r;
      cap_s      = 1'b0;
      err_s      = 1'b0;
      if (!onehot_s) begin
         state_nx_s = ST_IDLE;
         cnt_nx_s   = 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nx_s = ST_SETTLE;
               cnt_nx_s   = 8'd1;
               pat_nx_s   = sample_s;
            end
            ST_SETTLE: begin
               if (!same_s) begin
                  cnt_nx_s = 8'd1;
                  pat_nx_s = sample_s;
               end else if (cnt_r >= CNT_LAST) begin
                  // This sample is the STABLE_CYCLES-th identical one.
                  state_nx_s = ST_HELD;
                  cnt_nx_s   = CNT_LIMIT;
                  cap_s      = dec_vld_s;
                  err_s      = ~dec_vld_s;
               end else begin
                  cnt_nx_s = cnt_r + 8'd1;
               end
            end
            ST_HELD: begin
               if (!same_s) begin
                  state_nx_s = ST_SETTLE;
                  cnt_nx_s   = 8'd1;
                  pat_nx_s   = sample_s;
               end else begin
                  cnt_nx_s = cnt_r;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = 8'd0;
            end
         endcase
      end
   end

   // Scan state, saturating stability counter and reference sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         pat_r   <= 12'hFFF;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         pat_r   <= pat_nx_s;
      end
   end

   // Shadow slots and captured bits; a capture coinciding with frame
   // publication lands after the clear so it counts toward the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         captured_r   <= 4'h0;
         shadow_val_r <= 16'h0000;
         shadow_dp_r  <= 4'h0;
      end else begin
         captured_r <= (frame_done_s ? 4'h0 : captured_r) | cap_mask_s;
         if (cap_s) begin
            shadow_val_r[{idx_s, 2'b00} +: 4] <= dec_nib_s;
            shadow_dp_r[idx_s]                <= ~dp_r;
         end
      end
   end

   // Publish a completed frame and the one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_r       <= 16'h0000;
         dp_seen_r     <= 4'h0;
         frame_valid_r <= 1'b0;
         decode_err_r  <= 1'b0;
      end else begin
         frame_valid_r <= frame_done_s;
         decode_err_r  <= err_s;
         if (frame_done_s) begin
            value_r   <= shadow_val_r;
            dp_seen_r <= shadow_dp_r;
         end
      end
   end

   assign value       = value_r;
   assign dp_seen     = dp_seen_r;
   assign frame_valid = frame_valid_r;
   assign decode_err  = decode_err_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frames,
// a negedge monitor pops and compares on every frame_valid pulse and
// counts decode_err pulses against the expected count.
// Honours SEG_HEX_DECODE_EN for the hex-digit scenario.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [15:0] value;
   logic [3:0]  dp_seen;
   logic        frame_valid;
   logic        decode_err;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
   } frame_t;

   frame_t exp_q[$];
   int     total = 0;
   int     bad   = 0;
   int     err_seen = 0;
   int     err_exp  = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .value       (value),
      .dp_seen     (dp_seen),
      .frame_valid (frame_valid),
      .decode_err  (decode_err)
   );

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:  return 7'h40;
         1:  return 7'h79;
         2:  return 7'h24;
         3:  return 7'h30;
         4:  return 7'h19;
         5:  return 7'h12;
         6:  return 7'h02;
         7:  return 7'h78;
         8:  return 7'h00;
         9:  return 7'h10;
         10: return 7'h08;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Hold one input pattern for n rising edges.
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      @(negedge clk);
      an  = a;
      seg = s;
      dp  = d;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic digit(input int pos, input int val, input logic dp_lit, input int n);
      logic [3:0] a;
      a = ~(4'b0001 << pos);
      drive(a, seg_of(val), ~dp_lit, n);
   endtask

   task automatic blank(input int n);
      drive(4'hF, 7'h7F, 1'b1, n);
   endtask

   task automatic scan4(input int d3, input int d2, input int d1, input int d0,
                        input logic [3:0] dpm, input int n);
      digit(3, d3, dpm[3], n);
      digit(2, d2, dpm[2], n);
      digit(1, d1, dpm[1], n);
      digit(0, d0, dpm[0], n);
   endtask

   task automatic settle(input string name);
      blank(6);
      check({name, "_pending"}, exp_q.size(), 32'd0);
      check({name, "_errs"}, err_seen, err_exp);
   endtask

   // Monitor: count error pulses and score every published frame.
   always @(negedge clk) begin
      frame_t f;
      if (decode_err === 1'b1) err_seen++;
      if (frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame actual value=%h dp=%h expected none", value, dp_seen);
         end else begin
            f = exp_q.pop_front();
            check("frame_value", value, f.v);
            check("frame_dp", dp_seen, f.d);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      dp    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_value", value, 16'h0000);
      check("rst_dp_seen", dp_seen, 4'h0);
      check("rst_frame_valid", frame_valid, 1'b0);
      check("rst_decode_err", decode_err, 1'b0);
      rst_n = 1'b1;

      // Basic scan 1,2,3,4
      exp_q.push_back('{v: 16'h1234, d: 4'h0});
      scan4(1, 2, 3, 4, 4'b0000, 8);
      settle("scan1234");
      check("value_hold", value, 16'h1234);

      // Decimal point on digit2
      exp_q.push_back('{v: 16'h9075, d: 4'b0100});
      scan4(9, 0, 7, 5, 4'b0100, 8);
      settle("scan9075");

      // Too-short holds never capture
      scan4(8, 8, 8, 8, 4'b0000, 3);
      scan4(8, 8, 8, 8, 4'b0000, 3);
      settle("short_hold");

      // Blank pattern on a single anode is rejected exactly once
      drive(4'b1110, 7'h7F, 1'b1, 8);
      err_exp++;
      settle("blank_reject");

      // Two anodes low: no capture, then a clean frame
      drive(4'b0011, seg_of(8), 1'b1, 20);
      exp_q.push_back('{v: 16'h4321, d: 4'h0});
      scan4(4, 3, 2, 1, 4'b0000, 8);
      settle("multi_anode");

      // Re-capture overwrites the slot
      exp_q.push_back('{v: 16'h2345, d: 4'h0});
      digit(3, 1, 1'b0, 8);
      digit(3, 2, 1'b0, 8);
      digit(2, 3, 1'b0, 8);
      digit(1, 4, 1'b0, 8);
      digit(0, 5, 1'b0, 8);
      settle("overwrite");

      // Reset mid-frame discards the partial frame
      digit(3, 9, 1'b0, 8);
      digit(2, 9, 1'b0, 8);
      digit(1, 9, 1'b0, 8);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_value", value, 16'h0000);
      check("midrst_dp_seen", dp_seen, 4'h0);
      check("midrst_frame_valid", frame_valid, 1'b0);
      check("midrst_decode_err", decode_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      blank(4);
      digit(0, 8, 1'b0, 8);
      settle("post_rst_partial");
      exp_q.push_back('{v: 16'h5678, d: 4'h0});
      digit(3, 5, 1'b0, 8);
      digit(2, 6, 1'b0, 8);
      digit(1, 7, 1'b0, 8);
      settle("post_rst_frame");

      // Hex digit A with dp on digit0
`ifdef SEG_HEX_DECODE_EN
      exp_q.push_back('{v: 16'h000A, d: 4'b0001});
`else
      err_exp++;
`endif
      scan4(0, 0, 0, 10, 4'b0001, 8);
      settle("hex_a");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
